// File: rtl/seq_mult_4bit.sv
// Sequential shift-and-add unsigned multiplier: one reused ripple-carry adder,
// WIDTH RUN cycles per operand pair, product shown live in DONE and held afterwards.

module seq_mult_rca #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    always_comb begin
        logic w_carry;
        o_sum   = '0;
        w_carry = i_cin;
        for (int i = 0; i < WIDTH; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_carry;
    end
endmodule

// state | meaning
// IDLE  | waiting for start; operands captured on accept
// RUN   | one add/shift step per cycle, WIDTH steps
// DONE  | done pulse; product is the live {upper,q}, registered on exit
module seq_mult_4bit #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_upper;
    logic [WIDTH-1:0]   r_q;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_product;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;

    assign w_addend = r_q[0] ? r_mcand : '0;

    seq_mult_rca #(.WIDTH(WIDTH)) u_adder (
        .i_a    (r_upper),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The carry out must land in the upper MSB, otherwise large products truncate.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_upper   <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand <= a;
                        r_q     <= b;
                        r_upper <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_upper <= {w_cout, w_sum[WIDTH-1:1]};
                    r_q     <= {w_sum[0], r_q[WIDTH-1:1]};
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                S_DONE: begin
                    r_product <= {r_upper, r_q};
                end
                default: ;
            endcase
        end
    end

    assign product = (r_state == S_DONE) ? {r_upper, r_q} : r_product;
endmodule

// File: tb/tb_seq_mult_4bit.sv
// Self-checking bench for seq_mult_4bit: directed cases, reset interplay,
// ignored starts during RUN, exhaustive and random pairs against a*b.

module tb_seq_mult_4bit;
    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [2*W-1:0] product;

    int checks   = 0;
    int failures = 0;

    seq_mult_4bit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: product = a*b after exactly W busy cycles, then one done cycle.
    task automatic run_mult(input logic [W-1:0] ta, input logic [W-1:0] tb_, input string tag,
                            input bit junk);
        int nb;
        int exp_p;
        exp_p = int'(ta) * int'(tb_);
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb_;
        tick();
        start = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 20) begin
            nb++;
            if (junk) begin
                start = 1'($urandom_range(0, 1));
                a     = W'($urandom);
                b     = W'($urandom);
            end
            tick();
        end
        start = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(nb), 32'(W));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_product"}, 32'(product), 32'(exp_p));
        tick();
        chk({tag, "_done_drop"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_held"}, 32'(product), 32'(exp_p));
    endtask

    initial begin
        int nb;
        int ndone;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // Reset held two cycles, then released.
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rel_busy", 32'(busy), 32'd0);
        chk("rel_done", 32'(done), 32'd0);
        chk("rel_product", 32'(product), 32'd0);

        run_mult(4'd7, 4'd3, "m7x3", 1'b0);
        run_mult(4'd15, 4'd15, "m15x15", 1'b0);
        run_mult(4'd0, 4'd9, "m0x9", 1'b0);
        run_mult(4'd12, 4'd0, "m12x0", 1'b0);

        // start during RUN with new operands must be ignored.
        @(negedge clk);
        start = 1'b1;
        a     = 4'd5;
        b     = 4'd5;
        tick();
        a     = 4'd2;
        b     = 4'd2;
        nb    = 0;
        ndone = 0;
        while (busy === 1'b1 && nb < 20) begin
            nb++;
            tick();
        end
        start = 1'b0;
        chk("ign_busy_cycles", 32'(nb), 32'd4);
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_product", 32'(product), 32'd25);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1) ndone++;
            chk("ign_still_idle", 32'(busy), 32'd0);
            chk("ign_held", 32'(product), 32'd25);
        end
        chk("ign_single_done", 32'(ndone), 32'd0);

        // Reset in the second RUN cycle discards the partial result.
        @(negedge clk);
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd11;
        tick();
        start = 1'b0;
        chk("abort_run1", 32'(busy), 32'd1);
        tick();
        chk("abort_run2", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_product", 32'(product), 32'd0);
        run_mult(4'd3, 4'd4, "m3x4", 1'b0);

        // rst and start on the same edge: stays IDLE.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        a     = 4'd6;
        b     = 4'd6;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", 32'(busy), 32'd0);
        tick();
        chk("rst_start_stay", 32'(busy), 32'd0);

        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                run_mult(4'(ia), 4'(ib), "sweep", 1'((ia + ib) % 2));
            end
        end

        for (int k = 0; k < 40; k++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) tick();
            run_mult(4'($urandom), 4'($urandom), "rand", 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
